// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the bit counter width helper.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Width of the bit counter; WIDTH=2 still needs one bit to count 0..1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshakes of the serial adder, grouped as one bundle.
// The slave side is the controller; the master side is the source/consumer.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/Half_Adder.sv
// Legacy half adder cell, reused as-is by the serial full-adder slice.
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic Sum,
  output logic Carry
);
  assign Sum   = a ^ b;
  assign Carry = a & b;
endmodule

// File: rtl/serial_fa_slice.sv
// One full-adder bit built from two half adders; the carry flop that closes
// the loop lives in the controller.
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic ha0_sum, ha0_carry, ha1_carry;

  Half_Adder HA0 (
    .a     (a),
    .b     (b),
    .Sum   (ha0_sum),
    .Carry (ha0_carry)
  );

  Half_Adder HA1 (
    .a     (ha0_sum),
    .b     (cin),
    .Sum   (sum),
    .Carry (ha1_carry)
  );

  assign cout = ha0_carry | ha1_carry;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts an operand pair, adds one bit per cycle
// LSB first through a shared full-adder slice, then holds the result until taken.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             out_of_reset;
  logic             sum_bit;
  logic             carry_nxt;

  serial_fa_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (sum_bit),
    .cout (carry_nxt)
  );

  // in_ready stays low during reset and rises on the first edge after release.
  assign bus.in_ready  = (state == IDLE) && out_of_reset;
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == RUN) || (state == DONE);
  assign bus.sum       = s_sh;
  assign bus.cout      = carry;

  // NOTE: all state updates use <= so every register sees pre-edge values,
  // which keeps the shift registers and carry flop moving in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      s_sh         <= '0;
      carry        <= 1'b0;
      bit_cnt      <= '0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            s_sh    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          s_sh    <= {sum_bit, s_sh[WIDTH-1:1]};
          carry   <= carry_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8, 4 and 2, using a vector
// table, hand-written corner sequences and per-instance result scoreboards.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();
  serial_add_ctrl_if #(.WIDTH(2)) bus2 ();
  logic busy8, busy4, busy2;

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .busy(busy8));
  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4));
  serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .busy(busy2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {cout, sum}, pushed on accept and popped on the result handshake.
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [2:0] q2[$];

  always @(negedge clk) begin : mon8
    logic [8:0] e;
    if (bus8.out_valid && bus8.out_ready) begin
      check("sb8_expected", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("sb8_result", {bus8.cout, bus8.sum}, e);
      end
    end
  end

  always @(negedge clk) begin : mon4
    logic [4:0] e;
    if (bus4.out_valid && bus4.out_ready) begin
      check("sb4_expected", q4.size() > 0, 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("sb4_result", {bus4.cout, bus4.sum}, e);
      end
    end
  end

  always @(negedge clk) begin : mon2
    logic [2:0] e;
    if (bus2.out_valid && bus2.out_ready) begin
      check("sb2_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("sb2_result", {bus2.cout, bus2.sum}, e);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
    int n = 0;
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept8_ready", bus8.in_ready, 1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    q8.push_back(exp);
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!bus8.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, n, prev;
    logic [3:0] a4, b4;
    logic [1:0] a2, b2;

    vecs[0] = '{8'h03, 8'h05, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[6] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
    vecs[7] = '{8'h01, 8'h7F, 8'h80, 1'b0};

    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  bus8.in_ready, 0);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_busy",      busy8, 0);
    check("rst_sum",       bus8.sum, 0);
    check("rst_cout",      bus8.cout, 0);
    check("rst_in_ready4", bus4.in_ready, 0);
    rst = 1'b0;
    #1;
    check("release_in_ready_low", bus8.in_ready, 0);
    @(posedge clk); #1;
    check("release_in_ready_high", bus8.in_ready, 1);

    // Table-driven operand pairs with out_ready held high
    for (int i = 0; i < 8; i++) begin
      accept8(vecs[i].a, vecs[i].b, {vecs[i].cout, vecs[i].sum});
      check("tbl_busy_run", busy8, 1);
      wait_valid8(lat);
      check("tbl_latency", lat, 8);
      check("tbl_sum", bus8.sum, vecs[i].sum);
      check("tbl_cout", bus8.cout, vecs[i].cout);
      @(posedge clk); #1;
      check("tbl_out_valid_drop", bus8.out_valid, 0);
      check("tbl_idle_ready", bus8.in_ready, 1);
      check("tbl_idle_busy", busy8, 0);
    end

    // Back-pressure: result must hold while out_ready is low
    bus8.out_ready = 1'b0;
    accept8(8'h5A, 8'hC3, 9'h11D);
    wait_valid8(lat);
    check("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus8.out_valid, 1);
      check("bp_in_ready", bus8.in_ready, 0);
      check("bp_sum", bus8.sum, 8'h1D);
      check("bp_cout", bus8.cout, 1);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", bus8.out_valid, 0);
    check("bp_release_busy", busy8, 0);
    check("bp_release_in_ready", bus8.in_ready, 1);

    // Operands offered during RUN are ignored
    accept8(8'h3C, 8'h0F, 9'h04B);
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bus8.in_valid = (k % 2 == 0);
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    wait_valid8(lat);
    check("ign_latency", lat, 4);
    check("ign_sum", bus8.sum, 8'h4B);
    check("ign_cout", bus8.cout, 0);
    @(posedge clk); #1;

    // Reset mid-RUN at bit_cnt == 3
    accept8(8'h77, 8'h11, 9'h088);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(q8.pop_back());
    check("mid_rst_in_ready",  bus8.in_ready, 0);
    check("mid_rst_out_valid", bus8.out_valid, 0);
    check("mid_rst_busy",      busy8, 0);
    check("mid_rst_sum",       bus8.sum, 0);
    check("mid_rst_cout",      bus8.cout, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_hold_valid", bus8.out_valid, 0);
    rst = 1'b0;
    check("mid_rst_release_ready", bus8.in_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_ready_back", bus8.in_ready, 1);
    accept8(8'd10, 8'd20, 9'd30);
    wait_valid8(lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_sum", bus8.sum, 8'd30);
    @(posedge clk); #1;

    // WIDTH=4: all 256 pairs back-to-back, interval must be WIDTH+2
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4);
      b4 = 4'(i & 15);
      bus4.a = a4;
      bus4.b = b4;
      bus4.in_valid = 1'b1;
      n = 0;
      while (!bus4.in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      check("ex4_ready", bus4.in_ready, 1);
      @(posedge clk); #1;
      if (i > 0) check("ex4_interval", cyc - prev, 6);
      prev = cyc;
      q4.push_back({1'b0, a4} + {1'b0, b4});
    end
    bus4.in_valid = 1'b0;
    n = 0;
    while (q4.size() > 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end

    // WIDTH=2 boundary: RUN lasts two cycles, interval four
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i >> 2);
      b2 = 2'(i & 3);
      bus2.a = a2;
      bus2.b = b2;
      bus2.in_valid = 1'b1;
      n = 0;
      while (!bus2.in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      check("w2_ready", bus2.in_ready, 1);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      if (i > 0) check("w2_interval", cyc - prev, 4);
      prev = cyc;
      q2.push_back({1'b0, a2} + {1'b0, b2});
      n = 0;
      while (!bus2.out_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      check("w2_latency", n, 2);
    end
    n = 0;
    while (q2.size() > 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end

    check("sb8_drain", q8.size(), 0);
    check("sb4_drain", q4.size(), 0);
    check("sb2_drain", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares one full-adder slice, built from two `Half_Adder` instances plus a carry flop, to add two WIDTH-bit operands.
- Accepts operands over a valid/ready handshake.
- Sequences one bit per cycle, LSB first.
- Presents the sum and carry-out over a second valid/ready handshake.
- Sits between an operand source and a result consumer wherever area matters more than throughput.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width; legal range 2..64.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: controller can accept operands.
- `a` input WIDTH: operand A, sampled on accept.
- `b` input WIDTH: operand B, sampled on accept.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: a+b modulo 2^WIDTH.
- `cout` output 1: carry out of bit WIDTH-1.
- `busy` output 1: high in RUN or DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE; binary encoded, registered.
- **IDLE:** `in_ready`=1.
  - On `in_valid`&&`in_ready`: load `a` and `b` into shift registers A_sh and B_sh, clear `carry`, clear `bit_cnt` and the sum shift register S_sh, then go to RUN.
- **RUN, each cycle:**
  - HA0 = (A_sh[0], B_sh[0]).
  - HA1 = (HA0.Sum, `carry`).
  - New sum bit = HA1.Sum; new carry = HA0.Carry | HA1.Carry.
  - A_sh and B_sh shift right by 1, zero filled.
  - S_sh shifts right with the new sum bit entering at [WIDTH-1].
  - `bit_cnt` increments.
  - When `bit_cnt`==WIDTH-1, go to DONE on this edge.
- **DONE:** `out_valid`=1; `sum`=S_sh; `cout`=`carry`.
  - On `out_ready`: go to IDLE.
  - `sum` and `cout` stay stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` is ignored in RUN and DONE. No queuing; the source must hold `a` and `b` until accepted.
- `bit_cnt` width is $clog2(WIDTH). Arithmetic is unsigned; overflow is reported only through `cout`.

## Timing
- **Reset values:** state=IDLE; A_sh=B_sh=S_sh=0; `carry`=0; `bit_cnt`=0; `out_valid`=0; `sum`=0; `cout`=0; `busy`=0. `in_ready`=0 while `rst` is high and 1 from the first edge after release.
- **Outputs:** `in_ready`, `out_valid` and `busy` are decoded from the registered state only. No combinational path from inputs to outputs.
- **Latency:** accept on edge T → RUN during cycles T+1..T+WIDTH → `out_valid`=1 from edge T+WIDTH onward.
- **Throughput:** at most one operation per WIDTH+2 cycles. The DONE→IDLE transition always inserts one IDLE cycle, so a new accept cannot coincide with the result handshake.
- **Back-pressure:** DONE persists indefinitely while `out_ready`=0.
- **`out_ready` outside DONE:** has no effect.
- **Reset mid-operation:** an asserted `rst` in RUN or DONE immediately forces IDLE and the reset values above. The in-flight result is discarded, with no `out_valid` pulse.
- **WIDTH=2 boundary:** RUN lasts exactly 2 cycles; the `bit_cnt` compare must still terminate correctly.

## Structure
- Shared package `serial_add_pkg` holds:
  - the state typedef and encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the `bit_cnt` width function.
- Existing `Half_Adder` is reused unchanged, instantiated twice as HA0 and HA1.
- Natural sub-module: `serial_fa_slice`, which wraps HA0, HA1 and the OR of the two carries. The FSM, shift registers and carry flop stay in `serial_add_ctrl`.

## Test plan
- **Basic add:** WIDTH=8, a=3, b=5 → `sum`=8, `cout`=0, `out_valid` rises exactly 8 edges after accept.
- **Carry wrap:** a=8'hFF, b=8'h01 → `sum`=8'h00, `cout`=1. Then a=8'hFF, b=8'hFF → `sum`=8'hFE, `cout`=1.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles in DONE → `sum` and `cout` are stable and `in_ready`=0 throughout. `out_ready`=1 → IDLE next edge, and `in_ready`=1 the following cycle.
- **Ignored input:** toggle `in_valid` with new a and b during RUN → the result reflects only the originally accepted operands.
- **Reset mid-RUN:** assert `rst` at `bit_cnt`=3 → state IDLE, all outputs at reset values, no `out_valid`. After release, 10+20 → `sum`=30.
- **Exhaustive check:** WIDTH=4, all 256 operand pairs back-to-back with `out_ready`=1 → every result matches a+b, and the interval between accepts is exactly WIDTH+2 cycles.
